// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, functs, ALU op classes, PC-source selects
// and the control bundle handed from ID to EX.
package mips_pkg;

    localparam int NB_DATA     = 32;
    localparam int NB_REG_ADDR = 5;
    localparam int N_REGS      = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_LUI = 3'd5,
        ALU_NOR = 3'd6,
        ALU_XOR = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2
    } pc_src_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        logic    reg_dst;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = ctrl_t'(9'd0);

    function automatic ctrl_t mk_ctrl(input logic rw, input logic mr, input logic mw,
                                      input logic m2r, input logic as, input logic rdst,
                                      input alu_op_e op);
        ctrl_t c;
        c.reg_write  = rw;
        c.mem_read   = mr;
        c.mem_write  = mw;
        c.mem_to_reg = m2r;
        c.alu_src    = as;
        c.reg_dst    = rdst;
        c.alu_op     = op;
        return c;
    endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// 32x32 register file: two combinational write-first read ports, one write port,
// $0 hardwired to zero, synchronous clear on reset.
module reg_file
    import mips_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_we,
    input  logic [NB_REG_ADDR-1:0] i_waddr,
    input  logic [NB_DATA-1:0]     i_wdata,
    input  logic [NB_REG_ADDR-1:0] i_raddr_a,
    input  logic [NB_REG_ADDR-1:0] i_raddr_b,
    output logic [NB_DATA-1:0]     o_rdata_a,
    output logic [NB_DATA-1:0]     o_rdata_b
);

    logic [NB_DATA-1:0] r_regs [N_REGS];

    // Storage update: clear everything on reset, never write $0
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Port A read with same-cycle writeback bypass
    always_comb begin
        if (i_raddr_a == 5'd0) begin
            o_rdata_a = '0;
        end else if (i_we && (i_waddr == i_raddr_a)) begin
            o_rdata_a = i_wdata;
        end else begin
            o_rdata_a = r_regs[i_raddr_a];
        end
    end

    // Port B read with same-cycle writeback bypass
    always_comb begin
        if (i_raddr_b == 5'd0) begin
            o_rdata_b = '0;
        end else if (i_we && (i_waddr == i_raddr_b)) begin
            o_rdata_b = i_wdata;
        end else begin
            o_rdata_b = r_regs[i_raddr_b];
        end
    end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID register, register file, control decode, in-ID branch/jump
// resolution and load-use / branch-operand hazard detection.
module id_stage
    import mips_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NB_DATA-1:0]     i_next_pc,
    input  logic [NB_DATA-1:0]     i_instr,
    input  logic                   i_wb_we,
    input  logic [NB_REG_ADDR-1:0] i_wb_addr,
    input  logic [NB_DATA-1:0]     i_wb_data,
    input  logic                   i_ex_reg_write,
    input  logic                   i_ex_mem_read,
    input  logic [NB_REG_ADDR-1:0] i_ex_dst,
    input  logic                   i_mem_reg_write,
    input  logic [NB_REG_ADDR-1:0] i_mem_dst,
    output logic                   o_stall,
    output logic [1:0]             o_pc_src,
    output logic [NB_DATA-1:0]     o_branch_target,
    output logic [NB_DATA-1:0]     o_jump_target,
    output logic [NB_DATA-1:0]     o_next_pc,
    output logic [NB_DATA-1:0]     o_rs_data,
    output logic [NB_DATA-1:0]     o_rt_data,
    output logic [NB_DATA-1:0]     o_imm_ext,
    output logic [NB_REG_ADDR-1:0] o_rs,
    output logic [NB_REG_ADDR-1:0] o_rt,
    output logic [NB_REG_ADDR-1:0] o_rd,
    output logic                   o_reg_write,
    output logic                   o_mem_read,
    output logic                   o_mem_write,
    output logic                   o_mem_to_reg,
    output logic                   o_alu_src,
    output logic                   o_reg_dst,
    output logic [2:0]             o_alu_op
);

    logic [NB_DATA-1:0]     r_instr;
    logic [NB_DATA-1:0]     r_next_pc;
    logic                   r_valid;

    logic [5:0]             w_op;
    logic [5:0]             w_funct;
    logic [NB_REG_ADDR-1:0] w_rs;
    logic [NB_REG_ADDR-1:0] w_rt;
    logic [15:0]            w_imm;
    logic [NB_DATA-1:0]     w_rs_data;
    logic [NB_DATA-1:0]     w_rt_data;
    logic [NB_DATA-1:0]     w_imm_ext;
    ctrl_t                  w_ctrl_dec;
    ctrl_t                  w_ctrl;
    logic                   w_rt_src;
    logic                   w_is_branch;
    logic                   w_load_use;
    logic                   w_br_hazard;
    logic                   w_stall;
    pc_src_e                w_pc_src;
    logic                   w_flush;

    assign w_op    = r_instr[31:26];
    assign w_rs    = r_instr[25:21];
    assign w_rt    = r_instr[20:16];
    assign w_imm   = r_instr[15:0];
    assign w_funct = r_instr[5:0];

    // IF/ID register: reset > stall hold > flush to NOP > load from fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr   <= NOP_INSTR;
            r_next_pc <= '0;
            r_valid   <= 1'b0;
        end else if (w_stall) begin
            r_instr   <= r_instr;
            r_next_pc <= r_next_pc;
            r_valid   <= r_valid;
        end else if (w_flush) begin
            r_instr   <= NOP_INSTR;
            r_next_pc <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_instr   <= i_instr;
            r_next_pc <= i_next_pc;
            r_valid   <= 1'b1;
        end
    end

    reg_file u_reg_file (
        .clk       (clk),
        .reset     (reset),
        .i_we      (i_wb_we),
        .i_waddr   (i_wb_addr),
        .i_wdata   (i_wb_data),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_rs_data),
        .o_rdata_b (w_rt_data)
    );

    // Opcode / funct to control bundle
    always_comb begin
        w_ctrl_dec = CTRL_NOP;
        case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    FN_ADD, FN_ADDU: w_ctrl_dec = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD);
                    FN_SUB, FN_SUBU: w_ctrl_dec = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_SUB);
                    FN_AND:  w_ctrl_dec = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_AND);
                    FN_OR:   w_ctrl_dec = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_OR);
                    FN_XOR:  w_ctrl_dec = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_XOR);
                    FN_NOR:  w_ctrl_dec = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_NOR);
                    FN_SLT:  w_ctrl_dec = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_SLT);
                    default: w_ctrl_dec = CTRL_NOP;
                endcase
            end
            OP_LW:   w_ctrl_dec = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, ALU_ADD);
            OP_SW:   w_ctrl_dec = mk_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ALU_ADD);
            OP_BEQ, OP_BNE: w_ctrl_dec = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_SUB);
            OP_ADDI: w_ctrl_dec = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_ADD);
            OP_SLTI: w_ctrl_dec = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_SLT);
            OP_ANDI: w_ctrl_dec = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_AND);
            OP_ORI:  w_ctrl_dec = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_OR);
            OP_LUI:  w_ctrl_dec = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_LUI);
            OP_J:    w_ctrl_dec = CTRL_NOP;
            default: w_ctrl_dec = CTRL_NOP;
        endcase
    end

    // Immediate extension: logical ops zero-extend, lui shifts into the upper half
    always_comb begin
        w_imm_ext = {{16{w_imm[15]}}, w_imm};
        case (w_op)
            OP_ANDI, OP_ORI: w_imm_ext = {16'h0000, w_imm};
            OP_LUI:          w_imm_ext = {w_imm, 16'h0000};
            default:         w_imm_ext = {{16{w_imm[15]}}, w_imm};
        endcase
    end

    assign w_rt_src    = (w_op == OP_RTYPE) || (w_op == OP_SW) || (w_op == OP_BEQ) || (w_op == OP_BNE);
    assign w_is_branch = (w_op == OP_BEQ) || (w_op == OP_BNE);

    assign w_load_use = r_valid && i_ex_mem_read && (i_ex_dst != 5'd0) &&
                        ((i_ex_dst == w_rs) || ((i_ex_dst == w_rt) && w_rt_src));

    // Branches compare in ID, so any producer still in EX or MEM must drain first
    assign w_br_hazard = r_valid && w_is_branch &&
                         ((i_ex_reg_write && (i_ex_dst != 5'd0) &&
                           ((i_ex_dst == w_rs) || (i_ex_dst == w_rt))) ||
                          (i_mem_reg_write && (i_mem_dst != 5'd0) &&
                           ((i_mem_dst == w_rs) || (i_mem_dst == w_rt))));

    assign w_stall = w_load_use || w_br_hazard;

    // PC source select; a stalled or invalid slot never redirects fetch
    always_comb begin
        w_pc_src = PC_SEQ;
        if (r_valid && !w_stall) begin
            case (w_op)
                OP_BEQ:  w_pc_src = (w_rs_data == w_rt_data) ? PC_BRANCH : PC_SEQ;
                OP_BNE:  w_pc_src = (w_rs_data != w_rt_data) ? PC_BRANCH : PC_SEQ;
                OP_J:    w_pc_src = PC_JUMP;
                default: w_pc_src = PC_SEQ;
            endcase
        end else begin
            w_pc_src = PC_SEQ;
        end
    end

    assign w_flush = (w_pc_src != PC_SEQ);
    assign w_ctrl  = (r_valid && !w_stall) ? w_ctrl_dec : CTRL_NOP;

    assign o_stall         = w_stall;
    assign o_pc_src        = w_pc_src;
    assign o_branch_target = r_next_pc + {{14{w_imm[15]}}, w_imm, 2'b00};
    assign o_jump_target   = {r_next_pc[31:28], r_instr[25:0], 2'b00};
    assign o_next_pc       = r_next_pc;
    assign o_rs_data       = w_rs_data;
    assign o_rt_data       = w_rt_data;
    assign o_imm_ext       = w_imm_ext;
    assign o_rs            = w_rs;
    assign o_rt            = w_rt;
    assign o_rd            = r_instr[15:11];
    assign o_reg_write     = w_ctrl.reg_write;
    assign o_mem_read      = w_ctrl.mem_read;
    assign o_mem_write     = w_ctrl.mem_write;
    assign o_mem_to_reg    = w_ctrl.mem_to_reg;
    assign o_alu_src       = w_ctrl.alu_src;
    assign o_reg_dst       = w_ctrl.reg_dst;
    assign o_alu_op        = w_ctrl.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: an instruction-level model of the decode stage checked on every
// falling edge, plus directed scenarios with hand-computed literal expectations.
module tb_id_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_next_pc, i_instr, i_wb_data;
    logic        i_wb_we, i_ex_reg_write, i_ex_mem_read, i_mem_reg_write;
    logic [4:0]  i_wb_addr, i_ex_dst, i_mem_dst;
    logic        o_stall;
    logic [1:0]  o_pc_src;
    logic [31:0] o_branch_target, o_jump_target, o_next_pc, o_rs_data, o_rt_data, o_imm_ext;
    logic [4:0]  o_rs, o_rt, o_rd;
    logic        o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_reg_dst;
    logic [2:0]  o_alu_op;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .reset(reset), .i_next_pc(i_next_pc), .i_instr(i_instr),
        .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .i_ex_reg_write(i_ex_reg_write), .i_ex_mem_read(i_ex_mem_read), .i_ex_dst(i_ex_dst),
        .i_mem_reg_write(i_mem_reg_write), .i_mem_dst(i_mem_dst),
        .o_stall(o_stall), .o_pc_src(o_pc_src), .o_branch_target(o_branch_target),
        .o_jump_target(o_jump_target), .o_next_pc(o_next_pc), .o_rs_data(o_rs_data),
        .o_rt_data(o_rt_data), .o_imm_ext(o_imm_ext), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
        .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_mem_to_reg(o_mem_to_reg), .o_alu_src(o_alu_src), .o_reg_dst(o_reg_dst),
        .o_alu_op(o_alu_op)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_instr, m_npc;
    logic        m_valid;
    logic        m_ok = 1'b0;

    typedef struct packed {
        logic        stall;
        logic [1:0]  pc_src;
        logic [31:0] bt, jt, npc, rsd, rtd, imm;
        logic [4:0]  rs, rt, rd;
        logic [8:0]  ctl;   // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op}
    } exp_t;

    function automatic logic [31:0] rf_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (i_wb_we && i_wb_addr == a) return i_wb_data;
        return m_regs[a];
    endfunction

    function automatic logic [8:0] ctl_of(input logic [31:0] ins);
        logic [5:0] op = ins[31:26];
        logic [5:0] fn = ins[5:0];
        if (op == 6'h00) begin
            if (fn == 6'h20 || fn == 6'h21) return {6'b100001, ALU_ADD};
            if (fn == 6'h22 || fn == 6'h23) return {6'b100001, ALU_SUB};
            if (fn == 6'h24) return {6'b100001, ALU_AND};
            if (fn == 6'h25) return {6'b100001, ALU_OR};
            if (fn == 6'h26) return {6'b100001, ALU_XOR};
            if (fn == 6'h27) return {6'b100001, ALU_NOR};
            if (fn == 6'h2A) return {6'b100001, ALU_SLT};
            return 9'd0;
        end
        if (op == 6'h23) return {6'b110110, ALU_ADD};
        if (op == 6'h2B) return {6'b001010, ALU_ADD};
        if (op == 6'h04 || op == 6'h05) return {6'b000000, ALU_SUB};
        if (op == 6'h08) return {6'b100010, ALU_ADD};
        if (op == 6'h0A) return {6'b100010, ALU_SLT};
        if (op == 6'h0C) return {6'b100010, ALU_AND};
        if (op == 6'h0D) return {6'b100010, ALU_OR};
        if (op == 6'h0F) return {6'b100010, ALU_LUI};
        return 9'd0;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        logic [5:0]  op  = m_instr[31:26];
        logic [15:0] imm = m_instr[15:0];
        logic        rt_used, is_br, lu, bh;
        int          simm;
        e.rs  = m_instr[25:21];
        e.rt  = m_instr[20:16];
        e.rd  = m_instr[15:11];
        e.rsd = rf_read(e.rs);
        e.rtd = rf_read(e.rt);
        e.npc = m_npc;
        rt_used = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
        is_br   = (op == 6'h04) || (op == 6'h05);
        lu = m_valid && i_ex_mem_read && i_ex_dst != 5'd0 &&
             (i_ex_dst == e.rs || (rt_used && i_ex_dst == e.rt));
        bh = m_valid && is_br &&
             ((i_ex_reg_write && i_ex_dst != 5'd0 && (i_ex_dst == e.rs || i_ex_dst == e.rt)) ||
              (i_mem_reg_write && i_mem_dst != 5'd0 && (i_mem_dst == e.rs || i_mem_dst == e.rt)));
        e.stall = lu || bh;
        e.ctl   = (m_valid && !e.stall) ? ctl_of(m_instr) : 9'd0;
        e.pc_src = 2'd0;
        if (m_valid && !e.stall) begin
            if (op == 6'h04 && e.rsd == e.rtd) e.pc_src = 2'd1;
            if (op == 6'h05 && e.rsd != e.rtd) e.pc_src = 2'd1;
            if (op == 6'h02) e.pc_src = 2'd2;
        end
        simm = int'($signed(imm));
        e.bt = m_npc + 32'(simm * 4);
        e.jt = (m_npc & 32'hF000_0000) | ({6'd0, m_instr[25:0]} * 32'd4);
        if (op == 6'h0C || op == 6'h0D) e.imm = {16'd0, imm};
        else if (op == 6'h0F)           e.imm = 32'(imm) * 32'd65536;
        else                            e.imm = 32'(simm);
        return e;
    endfunction

    // Model state advance on the same edge as the DUT
    always @(posedge clk) begin : model_update
        exp_t e;
        e = model_out();
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
            m_instr <= 32'd0; m_npc <= 32'd0; m_valid <= 1'b0; m_ok <= 1'b1;
        end else begin
            if (i_wb_we && i_wb_addr != 5'd0) m_regs[i_wb_addr] <= i_wb_data;
            if (e.stall) begin
                m_instr <= m_instr;
            end else if (e.pc_src != 2'd0) begin
                m_instr <= 32'd0; m_npc <= 32'd0; m_valid <= 1'b0;
            end else begin
                m_instr <= i_instr; m_npc <= i_next_pc; m_valid <= 1'b1;
            end
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin : compare
        exp_t e;
        if (m_ok) begin
            e = model_out();
            chk("stall",      32'(o_stall), 32'(e.stall));
            chk("pc_src",     32'(o_pc_src), 32'(e.pc_src));
            chk("next_pc",    o_next_pc, e.npc);
            chk("rs_data",    o_rs_data, e.rsd);
            chk("rt_data",    o_rt_data, e.rtd);
            chk("imm_ext",    o_imm_ext, e.imm);
            chk("rs",         32'(o_rs), 32'(e.rs));
            chk("rt",         32'(o_rt), 32'(e.rt));
            chk("rd",         32'(o_rd), 32'(e.rd));
            chk("controls",   32'({o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg,
                                   o_alu_src, o_reg_dst, o_alu_op}), 32'(e.ctl));
            if (e.pc_src == 2'd1) chk("branch_target", o_branch_target, e.bt);
            if (e.pc_src == 2'd2) chk("jump_target", o_jump_target, e.jt);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ins, input logic [31:0] npc);
        i_instr = ins;
        i_next_pc = npc;
    endtask

    typedef struct packed {
        logic [31:0] ins;
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        ex_rw, ex_mr;
        logic [4:0]  ex_dst;
    } row_t;

    row_t tbl [15];

    initial begin
        reset = 1'b1;
        i_next_pc = 32'd0; i_instr = 32'd0; i_wb_we = 1'b0; i_wb_addr = 5'd0; i_wb_data = 32'd0;
        i_ex_reg_write = 1'b0; i_ex_mem_read = 1'b0; i_ex_dst = 5'd0;
        i_mem_reg_write = 1'b0; i_mem_dst = 5'd0;
        tick(); tick();

        reset = 1'b0;
        fetch(32'h2001_0005, 32'h0000_0004);            // addi $1,$0,5
        #1;
        chk("lit reset stall",   32'(o_stall), 32'd0);
        chk("lit reset pc_src",  32'(o_pc_src), 32'd0);
        chk("lit reset next_pc", o_next_pc, 32'd0);
        chk("lit reset rw",      32'(o_reg_write), 32'd0);
        tick();

        fetch(32'h0063_2020, 32'h0000_0008);            // add $4,$3,$3
        #1;
        chk("lit addi rw",  32'(o_reg_write), 32'd1);
        chk("lit addi as",  32'(o_alu_src), 32'd1);
        chk("lit addi imm", o_imm_ext, 32'd5);
        chk("lit addi rt",  32'(o_rt), 32'd1);
        tick();

        i_wb_we = 1'b1; i_wb_addr = 5'd3; i_wb_data = 32'hDEAD_BEEF;
        fetch(32'h0041_2820, 32'h0000_000C);            // add $5,$2,$1
        #1;
        chk("lit bypass rs", o_rs_data, 32'hDEAD_BEEF);
        chk("lit bypass rt", o_rt_data, 32'hDEAD_BEEF);
        chk("lit add reg_dst", 32'(o_reg_dst), 32'd1);
        tick();

        i_wb_we = 1'b0;
        i_ex_mem_read = 1'b1; i_ex_dst = 5'd2;
        fetch(32'h1021_0003, 32'h0000_0100);            // beq $1,$1,+3
        #1;
        chk("lit loaduse stall", 32'(o_stall), 32'd1);
        chk("lit loaduse rw",    32'(o_reg_write), 32'd0);
        tick();

        i_ex_mem_read = 1'b0; i_ex_dst = 5'd0;
        #1;
        chk("lit held rd",      32'(o_rd), 32'd5);
        chk("lit held next_pc", o_next_pc, 32'h0000_000C);
        chk("lit unstall",      32'(o_stall), 32'd0);
        tick();

        fetch(32'h2001_0005, 32'h0000_0104);
        #1;
        chk("lit beq pc_src", 32'(o_pc_src), 32'd1);
        chk("lit beq target", o_branch_target, 32'h0000_010C);
        tick();

        fetch(32'h0800_0040, 32'h8000_0004);            // j 0x40
        #1;
        chk("lit flushed rw",     32'(o_reg_write), 32'd0);
        chk("lit flushed pc_src", 32'(o_pc_src), 32'd0);
        tick();

        i_wb_we = 1'b1; i_wb_addr = 5'd0; i_wb_data = 32'h0000_1234;
        fetch(32'h2001_0005, 32'h8000_0008);
        #1;
        chk("lit j pc_src", 32'(o_pc_src), 32'd2);
        chk("lit j target", o_jump_target, 32'h8000_0100);
        tick();

        i_wb_we = 1'b0;
        fetch(32'h0000_3020, 32'h0000_0200);            // add $6,$0,$0
        tick();

        fetch(32'h1022_0001, 32'h0000_0300);            // beq $1,$2,+1
        #1;
        chk("lit r0 reads 0", o_rs_data, 32'd0);
        tick();

        i_mem_reg_write = 1'b1; i_mem_dst = 5'd1;
        #1;
        chk("lit brhaz stall",  32'(o_stall), 32'd1);
        chk("lit brhaz pc_src", 32'(o_pc_src), 32'd0);
        tick();

        reset = 1'b1;
        #1;
        chk("lit stall before reset", 32'(o_stall), 32'd1);
        tick();

        reset = 1'b0; i_mem_reg_write = 1'b0; i_mem_dst = 5'd0;
        fetch(32'h0063_2020, 32'h0000_0400);            // add $4,$3,$3
        #1;
        chk("lit post-reset stall",   32'(o_stall), 32'd0);
        chk("lit post-reset next_pc", o_next_pc, 32'd0);
        tick();
        #1;
        chk("lit regfile cleared", o_rs_data, 32'd0);

        // Decode sweep: ins, wb_we, wb_addr, wb_data, ex_rw, ex_mr, ex_dst
        tbl[0]  = {32'h3C07_8001, 1'b1, 5'd3, 32'h0000_0055, 1'b0, 1'b0, 5'd0};  // lui
        tbl[1]  = {32'h34E7_F00F, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0};          // ori
        tbl[2]  = {32'h30E8_FFFF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0};          // andi
        tbl[3]  = {32'h28E9_FFFF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0};          // slti
        tbl[4]  = {32'hAC27_0008, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0};          // sw
        tbl[5]  = {32'h8C28_0004, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd7};          // lw, sw rt hazard
        tbl[6]  = {32'h8C28_0004, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0};
        tbl[7]  = {32'h00E8_5022, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd8};          // sub, lw rt not a source
        tbl[8]  = {32'h1460_0002, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0};          // bne $3,$0
        tbl[9]  = {32'h2001_0005, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd3};          // EX hazard on bne
        tbl[10] = {32'h2001_0005, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0};
        tbl[11] = {32'h1060_0002, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0};          // beq $3,$0
        tbl[12] = {32'hFC00_0000, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0};          // unknown op
        tbl[13] = {32'h0000_0000, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0};
        tbl[14] = {32'h0000_0000, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0};
        for (int k = 0; k < 15; k++) begin
            fetch(tbl[k].ins, 32'h0000_0500 + 32'(k * 4));
            i_wb_we = tbl[k].wb_we; i_wb_addr = tbl[k].wb_addr; i_wb_data = tbl[k].wb_data;
            i_ex_reg_write = tbl[k].ex_rw; i_ex_mem_read = tbl[k].ex_mr; i_ex_dst = tbl[k].ex_dst;
            tick();
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
